// File: rtl/sdram_responder.sv
// Device side of a 32-bit SDR SDRAM bus: command decode, per-bank open-row
// tracking, a reduced word array and a CAS-latency read pipeline.
module sdram_responder #(
  parameter int ROW_W = 4,
  parameter int COL_W = 6
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [12:0] sdram_wire_addr,
  input  logic [1:0]  sdram_wire_ba,
  input  logic        sdram_wire_cas_n,
  input  logic        sdram_wire_cke,
  input  logic        sdram_wire_cs_n,
  inout  wire  [31:0] sdram_wire_dq,
  input  logic [3:0]  sdram_wire_dqm,
  input  logic        sdram_wire_ras_n,
  input  logic        sdram_wire_we_n,
  output logic        err_export,
  output logic [15:0] refresh_count_export
);
  localparam int AW    = 2 + ROW_W + COL_W;
  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  logic [31:0]            mem_q [DEPTH];
  logic [3:0]             bank_act_q, bank_act_d;
  logic [3:0][ROW_W-1:0]  bank_row_q, bank_row_d;
  logic                   mode_vld_q, mode_vld_d;
  logic                   cl3_q, cl3_d;
  logic                   err_q;
  logic [15:0]            ref_cnt_q;
  logic [1:0]             pipe_vld_q;
  logic [1:0][31:0]       pipe_data_q;
  logic [3:0]             pipe_dqm_q;
  logic [3:0]             out_oe_q;
  logic [31:0]            out_data_q;

  logic                   cmd_vld;
  logic [2:0]             cmd;
  logic                   a10;
  logic                   err_set, ref_inc, rd_ok, wr_ok;
  logic [AW-1:0]          idx;
  logic [31:0]            rd_word;
  logic                   unused_addr;

  assign cmd_vld     = ~sdram_wire_cs_n & sdram_wire_cke;
  assign cmd         = {sdram_wire_ras_n, sdram_wire_cas_n, sdram_wire_we_n};
  assign a10         = sdram_wire_addr[10];
  assign idx         = {sdram_wire_ba, bank_row_q[sdram_wire_ba], sdram_wire_addr[COL_W-1:0]};
  assign rd_word     = mem_q[idx];
  assign unused_addr = ^sdram_wire_addr;

  always_comb begin
    bank_act_d = bank_act_q;
    bank_row_d = bank_row_q;
    mode_vld_d = mode_vld_q;
    cl3_d      = cl3_q;
    err_set    = 1'b0;
    ref_inc    = 1'b0;
    rd_ok      = 1'b0;
    wr_ok      = 1'b0;
    if (cmd_vld) begin
      case (cmd)
        CMD_ACT: begin
          if (bank_act_q[sdram_wire_ba] || !mode_vld_q) err_set = 1'b1;
          else begin
            bank_act_d[sdram_wire_ba] = 1'b1;
            bank_row_d[sdram_wire_ba] = sdram_wire_addr[ROW_W-1:0];
          end
        end
        CMD_RD: begin
          if (!bank_act_q[sdram_wire_ba]) err_set = 1'b1;
          else begin
            rd_ok = 1'b1;
            if (a10) bank_act_d[sdram_wire_ba] = 1'b0;
          end
        end
        CMD_WR: begin
          // write data sampled while our own read data is on the bus
          if (|out_oe_q) err_set = 1'b1;
          if (!bank_act_q[sdram_wire_ba]) err_set = 1'b1;
          else begin
            wr_ok = 1'b1;
            if (a10) bank_act_d[sdram_wire_ba] = 1'b0;
          end
        end
        CMD_PRE: begin
          if (a10) bank_act_d = 4'h0;
          else     bank_act_d[sdram_wire_ba] = 1'b0;
        end
        CMD_REF: begin
          if (|bank_act_q) err_set = 1'b1;
          else             ref_inc = 1'b1;
        end
        CMD_LMR: begin
          if (|bank_act_q) err_set = 1'b1;
          else if ((sdram_wire_addr[6:4] == 3'd2 || sdram_wire_addr[6:4] == 3'd3) &&
                   sdram_wire_addr[2:0] == 3'd0) begin
            mode_vld_d = 1'b1;
            cl3_d      = (sdram_wire_addr[6:4] == 3'd3);
          end else begin
            err_set    = 1'b1;
            mode_vld_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bank_act_q  <= 4'h0;
      bank_row_q  <= '0;
      mode_vld_q  <= 1'b0;
      cl3_q       <= 1'b0;
      err_q       <= 1'b0;
      ref_cnt_q   <= 16'h0;
      pipe_vld_q  <= 2'b00;
      pipe_data_q <= '0;
      pipe_dqm_q  <= 4'h0;
      out_oe_q    <= 4'h0;
      out_data_q  <= 32'h0;
    end else begin
      bank_act_q <= bank_act_d;
      bank_row_q <= bank_row_d;
      mode_vld_q <= mode_vld_d;
      cl3_q      <= cl3_d;
      if (err_set) err_q <= 1'b1;
      if (ref_inc && ref_cnt_q != 16'hFFFF) ref_cnt_q <= ref_cnt_q + 16'd1;
      // stage 0 always holds the dqm seen two edges before its data cycle
      out_oe_q       <= pipe_vld_q[0] ? ~pipe_dqm_q : 4'h0;
      out_data_q     <= pipe_data_q[0];
      pipe_vld_q[1]  <= rd_ok & cl3_q;
      pipe_data_q[1] <= rd_word;
      if (rd_ok && !cl3_q) begin
        pipe_vld_q[0]  <= 1'b1;
        pipe_data_q[0] <= rd_word;
      end else begin
        pipe_vld_q[0]  <= pipe_vld_q[1];
        pipe_data_q[0] <= pipe_data_q[1];
      end
      pipe_dqm_q <= sdram_wire_dqm;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (wr_ok && !reset_reset) begin
      for (int i = 0; i < 4; i++)
        if (!sdram_wire_dqm[i]) mem_q[idx][8*i +: 8] <= sdram_wire_dq[8*i +: 8];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign sdram_wire_dq[8*g +: 8] = out_oe_q[g] ? out_data_q[8*g +: 8] : 8'hzz;
  end

  assign err_export           = err_q;
  assign refresh_count_export = ref_cnt_q;
endmodule
